// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window generator: default pixel width,
// tap index constants (raster order, top-left to bottom-right), FSM state
// encoding and the tap-to-buffer index helper.
package win_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned NUM_TAPS   = 9;

    localparam int unsigned TAP_TL = 0;
    localparam int unsigned TAP_T  = 1;
    localparam int unsigned TAP_TR = 2;
    localparam int unsigned TAP_L  = 3;
    localparam int unsigned TAP_C  = 4;
    localparam int unsigned TAP_R  = 5;
    localparam int unsigned TAP_BL = 6;
    localparam int unsigned TAP_B  = 7;
    localparam int unsigned TAP_BR = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } win_state_e;

    // Shift-buffer position of tap k (k = 3*dy + dx); position 0 is the newest pixel.
    function automatic int unsigned tap_buf_idx(input int unsigned k, input int unsigned img_w);
        return (2 - (k / 3)) * img_w + (2 - (k % 3));
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bundle of window_3x3_gen.
//   master : pixel source and window sink (drives in_valid/in_pixel)
//   slave  : the window generator (drives in_ready/out_valid/win)
// With WIN_POS_OUT_EN defined the bundle also carries out_row, out_col and
// out_last, and the IMG_W/IMG_H parameters that size them.
interface window_3x3_gen_if #(
    parameter int unsigned DATA_W = 8
`ifdef WIN_POS_OUT_EN
    ,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
`endif
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_pixel;
    logic                  out_valid;
    logic [9*DATA_W-1:0]   win;

`ifdef WIN_POS_OUT_EN
    logic [$clog2(IMG_H)-1:0] out_row;
    logic [$clog2(IMG_W)-1:0] out_col;
    logic                     out_last;

    modport master (
        output in_valid, in_pixel,
        input  in_ready, out_valid, win, out_row, out_col, out_last
    );

    modport slave (
        input  in_valid, in_pixel,
        output in_ready, out_valid, win, out_row, out_col, out_last
    );
`else
    modport master (
        output in_valid, in_pixel,
        input  in_ready, out_valid, win
    );

    modport slave (
        input  in_valid, in_pixel,
        output in_ready, out_valid, win
    );
`endif

endinterface

// File: rtl/pix_shift_reg.sv
// Pixel history shift register. On shift_en the newest pixel enters at
// entry 0 and every entry moves one place older.
//   clk      : rising-edge clock
//   shift_en : advance the buffer by one entry
//   din      : pixel shifted into entry 0
//   taps     : all entries, taps[i*DATA_W +: DATA_W] = entry i (0 = newest)
// Contents are intentionally not reset.
module pix_shift_reg #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 19
) (
    input  logic                    clk,
    input  logic                    shift_en,
    input  logic [DATA_W-1:0]       din,
    output logic [DEPTH*DATA_W-1:0] taps
);

    always_ff @(posedge clk) begin
        if (shift_en) begin
            taps <= {taps[(DEPTH-1)*DATA_W-1:0], din};
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator for a raster-order pixel stream. Emits one
// zero-padded window per image pixel, in raster order, one cycle after the
// accept (or flush cycle) that completes it.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of window_3x3_gen_if
//              in_valid/in_ready/in_pixel : pixel input handshake
//              out_valid/win              : window output, tap k at win[k*DATA_W +: DATA_W]
// Optional build macro WIN_POS_OUT_EN adds out_row/out_col/out_last on bus.
module window_3x3_gen
    import win_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic             clk,
    input  logic             rst,
    window_3x3_gen_if.slave  bus
);

    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned DEPTH = 2 * IMG_W + 3;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned FL_W  = $clog2(IMG_W + 2);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned WIN_W = NUM_TAPS * DATA_W;

    win_state_e              state;
    logic [CNT_W-1:0]        cnt;
    logic [FL_W-1:0]         fcnt;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [WIN_W-1:0]        win_q;

    logic                    accept_c;
    logic                    flush_c;
    logic                    shift_en_c;
    logic                    emit_c;
    logic [DATA_W-1:0]       shift_din_c;
    logic [DEPTH*DATA_W-1:0] taps;
    logic [DATA_W-1:0]       tap_c [NUM_TAPS];
    logic [WIN_W-1:0]        win_c;
    logic                    row_top_c;
    logic                    row_bot_c;
    logic                    col_lft_c;
    logic                    col_rgt_c;
    logic                    unused_taps;

    // Handshake and buffer control; flush cycles shift zeros.
    assign accept_c    = bus.in_valid & in_ready_q;
    assign flush_c     = (state == FLUSH);
    assign shift_en_c  = accept_c | flush_c;
    assign shift_din_c = accept_c ? bus.in_pixel : '0;
    assign emit_c      = flush_c | (accept_c && (cnt >= CNT_W'(IMG_W + 1)));

    pix_shift_reg #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_shift (
        .clk      (clk),
        .shift_en (shift_en_c),
        .din      (shift_din_c),
        .taps     (taps)
    );

    // Taps are read from the buffer as it will be after this cycle's shift,
    // so the window lands in win one cycle after the completing accept.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        localparam int unsigned J = tap_buf_idx(k, IMG_W);
        if (J == 0) begin : g_new
            assign tap_c[k] = shift_din_c;
        end else begin : g_old
            assign tap_c[k] = taps[(J-1)*DATA_W +: DATA_W];
        end
    end

    // Only a subset of the history feeds the window; the rest is pure delay.
    assign unused_taps = ^taps;

    // Border zero mask, keyed on the centre position of the window being emitted.
    assign row_top_c = (row == '0);
    assign row_bot_c = (row == ROW_W'(IMG_H - 1));
    assign col_lft_c = (col == '0);
    assign col_rgt_c = (col == COL_W'(IMG_W - 1));

    always_comb begin
        win_c = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (!(((k / 3) == 0 && row_top_c) ||
                  ((k / 3) == 2 && row_bot_c) ||
                  ((k % 3) == 0 && col_lft_c) ||
                  ((k % 3) == 2 && col_rgt_c))) begin
                win_c[k*DATA_W +: DATA_W] = tap_c[k];
            end
        end
    end

`ifdef WIN_POS_OUT_EN
    logic [ROW_W-1:0] out_row_q;
    logic [COL_W-1:0] out_col_q;
    logic             out_last_q;

    // Position outputs registered alongside win.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_row_q  <= '0;
            out_col_q  <= '0;
            out_last_q <= 1'b0;
        end else if (emit_c) begin
            out_row_q  <= row;
            out_col_q  <= col;
            out_last_q <= row_bot_c & col_rgt_c;
        end
    end

    assign bus.out_row  = out_row_q;
    assign bus.out_col  = out_col_q;
    assign bus.out_last = out_last_q;
`endif

    // FSM, pixel/flush counters, centre position and registered window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            fcnt        <= '0;
            row         <= '0;
            col         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            win_q       <= '0;
        end else begin
            out_valid_q <= emit_c;

            if (emit_c) begin
                win_q <= win_c;
                if (col_rgt_c) begin
                    col <= '0;
                    row <= row_bot_c ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state <= RUN;
                        cnt   <= CNT_W'(1);
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(NPIX - 1)) begin
                            state      <= FLUSH;
                            in_ready_q <= 1'b0;
                            fcnt       <= '0;
                        end
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + FL_W'(1);
                    if (fcnt == FL_W'(IMG_W)) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                        cnt        <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.win       = win_q;

endmodule
